channel_scan_mux: RTL and testbench
===================================

CHANNEL_SCAN_MUX -- requirements
Module: channel_scan_mux

Interface
REQ-001 Parameter WIDTH, default 4, bits per data channel (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (>=1).
REQ-003 Parameter DWELL, default 50_000_000, clock cycles per channel in auto mode (>=1).
REQ-004 Derived constant SELW SHALL equal max(1, clog2(CHANNELS)).
REQ-005 Clock  input  1  system clock; all state changes on its rising edge; one clock domain only.
REQ-006 Reset  input  1  reset, synchronous and active-high.
REQ-007 data_in  input  CHANNELS*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SELW  manual channel select.
REQ-009 mode  input  1  0 = manual select, 1 = auto scan.
REQ-010 hold  input  1  freezes auto scan while high; ignored in manual mode.
REQ-011 out_data  output  WIDTH  registered selected channel data.
REQ-012 out_valid  output  1  high when out_data holds a post-reset sample.
REQ-013 ch_idx  output  SELW  registered index of the currently selected channel.
REQ-014 wrap  output  1  one-cycle pulse on auto-scan wrap from CHANNELS-1 to 0.
REQ-015 sel_err  output  1  registered flag: manual sel >= CHANNELS in the previous cycle.
REQ-016 hex_ch  output  7  active-low seven-segment pattern of ch_idx (segment order g..a, bit 6 = g).

Function
REQ-017 Each cycle: next index computed from mode/sel/counter; ch_idx and out_data = data_in slice of next index both register on the same edge (1-cycle latency from sel/data_in).
REQ-018 Manual: sel < CHANNELS -> next index = sel, sel_err <= 0; sel >= CHANNELS -> ch_idx unchanged, out_data re-samples the unchanged channel, sel_err <= 1.
REQ-019 Auto: dwell counter counts 0..DWELL-1; at DWELL-1 with hold low, counter -> 0 and index advances by 1, CHANNELS-1 -> 0.
REQ-020 wrap SHALL be 1 for exactly the cycle after the CHANNELS-1 -> 0 advance registers; 0 in manual mode.
REQ-021 hold high in auto: counter and ch_idx frozen; out_data keeps sampling the frozen channel each cycle; release resumes the remaining count.
REQ-022 Mode change (either direction): counter cleared that cycle; auto scan starts from current ch_idx; manual takes sel from the first manual cycle.
REQ-023 CHANNELS = 1: ch_idx stays 0; wrap pulses once every DWELL cycles in auto.
REQ-024 DWELL = 1: index advances every non-held auto cycle.
REQ-025 sel_err SHALL be 0 in auto mode.

Reset
REQ-026 Reset high: ch_idx = 0, counter = 0, out_data = 0, out_valid = 0, wrap = 0, sel_err = 0, regardless of mode, hold, or an in-progress dwell.
REQ-027 First edge with Reset low SHALL load out_valid = 1 and a normal selection per REQ-017.

Configuration
REQ-028 Macro HEX_DISPLAY_EN defined: hex_ch is registered, updated on the same edge as ch_idx; pattern for index values 0..15 = hex digits 0..F; higher bits ignored.
REQ-029 HEX_DISPLAY_EN undefined: hex_ch tied to 7'h7F (blank); no decoder logic present; port list unchanged.

Structure
REQ-030 Shared package channel_scan_pkg holds the mode encoding constants (MODE_MANUAL = 0, MODE_AUTO = 1) and the 16-entry seven-segment pattern table constant.
REQ-031 One sub-module, seg7_lut (4-bit in, 7-bit active-low out, combinational), instantiated only under HEX_DISPLAY_EN.

Verification (WIDTH=4, CHANNELS=4, DWELL=3 unless stated)
REQ-032 Reset high 2 cycles, data_in = 16'hDCBA -> outputs all 0; first cycle after release: out_valid = 1, out_data = 4'hA, ch_idx = 0.
REQ-033 Manual, sel = 2 -> next cycle out_data = 4'hC, ch_idx = 2; data_in changed to 16'hD5BA -> next cycle out_data = 4'h5.
REQ-034 Auto from ch_idx 0 -> ch_idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap = 1 only in the first cycle of the final 0.
REQ-035 Hold high 5 cycles after counter = 1 on ch_idx 1 -> ch_idx frozen at 1; after release, advance to 2 occurs 2 cycles later.
REQ-036 CHANNELS = 3, manual, sel = 3 after sel = 1 -> ch_idx stays 1, sel_err = 1 next cycle; Reset mid-scan at ch_idx 2 -> next cycle ch_idx = 0.
REQ-037 HEX_DISPLAY_EN defined, ch_idx = 2 -> hex_ch = 7'b0100100; ch_idx = 0 -> 7'b1000000; undefined -> hex_ch = 7'h7F always.

Source files
------------

// File: rtl/channel_scan_pkg.sv
// channel_scan_pkg: mode encodings and active-low seven-segment table (g..a) shared by the scan mux.
package channel_scan_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO = 1'b1;
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/channel_scan_mux_seg7_lut.sv
// seg7_lut: combinational hex digit to active-low seven-segment pattern (bit 6 = g).
module seg7_lut
  import channel_scan_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = SEG7_TABLE[val];
endmodule

// File: rtl/channel_scan_mux.sv
// channel_scan_mux: registered manual/auto-scan channel selector; define HEX_DISPLAY_EN for a registered hex_ch digit.
module channel_scan_mux
  import channel_scan_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL = 50_000_000,
  localparam int SELW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SELW-1:0]           ch_idx,
  output logic                      wrap,
  output logic                      sel_err,
  output logic [6:0]                hex_ch
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [SELW:0] NCH = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);
  localparam logic [CW-1:0] CEND = CW'(DWELL - 1);
  logic [CW-1:0] cnt, cnt_n;
  logic [SELW-1:0] nidx;
  logic [WIDTH-1:0] nd;
  logic mode_q, auto, chg, at_end, adv, man_ok, err_n;
  // a mode change restarts the dwell without advancing, so auto resumes from the current channel
  always_comb begin
    auto = mode == MODE_AUTO;
    chg = mode != mode_q;
    at_end = cnt == CEND;
    adv = auto && !chg && !hold && at_end;
    man_ok = {1'b0, sel} < NCH;
    err_n = mode == MODE_MANUAL && !man_ok;
    nidx = auto ? (adv ? (ch_idx == LAST ? '0 : ch_idx + 1'b1) : ch_idx) : (man_ok ? sel : ch_idx);
    cnt_n = (!auto || chg) ? '0 : hold ? cnt : at_end ? '0 : cnt + 1'b1;
    nd = '0;
    for (int k = 0; k < CHANNELS; k++) nd = nidx == SELW'(k) ? data_in[k*WIDTH +: WIDTH] : nd;
  end
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (rst) begin
      ch_idx <= '0;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      wrap <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      ch_idx <= nidx;
      cnt <= cnt_n;
      out_data <= nd;
      out_valid <= 1'b1;
      wrap <= adv && ch_idx == LAST;
      sel_err <= err_n;
    end
  end
`ifdef HEX_DISPLAY_EN
  logic [6:0] seg;
  seg7_lut u_seg (.val(4'(nidx)), .seg(seg));
  always_ff @(posedge clk) hex_ch <= rst ? SEG7_TABLE[0] : seg;
`else
  assign hex_ch = 7'h7F;
`endif
endmodule

// File: tb/tb_channel_scan_mux.sv
// tb_channel_scan_mux: vector table, directed corner sequences and random run against a behavioural model.
module tb_channel_scan_mux;
  logic clk = 0, rst = 1, mode = 0, hold = 0;
  logic [1:0] sel = 0;
  logic [15:0] din = 16'hDCBA;
  logic [3:0] d0, d1;
  logic [1:0] i0, i1;
  logic v0, v1, w0, w1, e0, e1;
  logic [6:0] h0, h1;
  int n_run = 0, n_fail = 0;
  int m_idx[2], m_cnt[2], m_pm[2], x_data[2], x_valid[2], x_wrap[2], x_err[2];

  always #5 clk = ~clk;

  channel_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u0 (
    .clk(clk), .rst(rst), .data_in(din), .sel(sel), .mode(mode), .hold(hold),
    .out_data(d0), .out_valid(v0), .ch_idx(i0), .wrap(w0), .sel_err(e0), .hex_ch(h0));
  channel_scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u1 (
    .clk(clk), .rst(rst), .data_in(din[11:0]), .sel(sel), .mode(mode), .hold(hold),
    .out_data(d1), .out_valid(v1), .ch_idx(i1), .wrap(w1), .sel_err(e1), .hex_ch(h1));

  function automatic int seg_of(int v);
`ifdef HEX_DISPLAY_EN
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      default: return 7'h7F;
    endcase
`else
    return 7'h7F;
`endif
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scan behaviour: each channel shown for DWELL auto cycles, hold pauses time, mode switch restarts the dwell
  task automatic model(int d);
    int nch = d == 0 ? 4 : 3;
    if (rst) begin
      m_idx[d] = 0; m_cnt[d] = 0; x_data[d] = 0; x_valid[d] = 0; x_wrap[d] = 0; x_err[d] = 0;
    end else begin
      x_wrap[d] = 0;
      x_err[d] = 0;
      if (!mode) begin
        m_cnt[d] = 0;
        if (int'(sel) < nch) m_idx[d] = int'(sel);
        else x_err[d] = 1;
      end else if (m_pm[d] == 0) m_cnt[d] = 0;
      else if (!hold) begin
        m_cnt[d]++;
        if (m_cnt[d] == 3) begin
          m_cnt[d] = 0;
          x_wrap[d] = int'(m_idx[d] == nch - 1);
          m_idx[d] = (m_idx[d] + 1) % nch;
        end
      end
      x_data[d] = (int'(din) >> (4 * m_idx[d])) & 15;
      x_valid[d] = 1;
    end
    m_pm[d] = int'(mode);
  endtask

  task automatic step;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    chk("u0 ch_idx", i0, m_idx[0]);
    chk("u0 out_data", d0, x_data[0]);
    chk("u0 out_valid", v0, x_valid[0]);
    chk("u0 wrap", w0, x_wrap[0]);
    chk("u0 sel_err", e0, x_err[0]);
    chk("u0 hex_ch", h0, seg_of(m_idx[0]));
    chk("u1 ch_idx", i1, m_idx[1]);
    chk("u1 out_data", d1, x_data[1]);
    chk("u1 out_valid", v1, x_valid[1]);
    chk("u1 wrap", w1, x_wrap[1]);
    chk("u1 sel_err", e1, x_err[1]);
    chk("u1 hex_ch", h1, seg_of(m_idx[1]));
  endtask

  typedef struct packed {
    logic r;
    logic [15:0] din;
    logic [1:0] sel;
    logic mode;
    logic idx_v;
    logic [1:0] idx;
    logic [3:0] data;
    logic valid;
    logic wrap;
    logic err;
  } vec_t;

  vec_t tv[12];
  int exp34[13];

  initial begin
    tv[0]  = '{1'b1, 16'hDCBA, 2'd0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 16'hDCBA, 2'd0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 16'hDCBA, 2'd0, 1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 16'hDCBA, 2'd2, 1'b0, 1'b1, 2'd2, 4'hC, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 16'hD5BA, 2'd2, 1'b0, 1'b1, 2'd2, 4'h5, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 16'hD5BA, 2'd3, 1'b0, 1'b1, 2'd3, 4'hD, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 16'hD5BA, 2'd3, 1'b1, 1'b1, 2'd3, 4'hD, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 16'hD5BA, 2'd3, 1'b1, 1'b1, 2'd3, 4'hD, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 16'hD5BA, 2'd3, 1'b1, 1'b1, 2'd3, 4'hD, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 16'hD5BA, 2'd3, 1'b1, 1'b1, 2'd0, 4'hA, 1'b1, 1'b1, 1'b0};
    tv[10] = '{1'b0, 16'hD5BA, 2'd3, 1'b1, 1'b1, 2'd0, 4'hA, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 16'hD5BA, 2'd1, 1'b0, 1'b1, 2'd1, 4'hB, 1'b1, 1'b0, 1'b0};
    exp34 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    #2;
    for (int i = 0; i < 12; i++) begin
      rst = tv[i].r; din = tv[i].din; sel = tv[i].sel; mode = tv[i].mode; hold = 0;
      step();
      chk("tv ch_idx", i0, tv[i].idx);
      chk("tv out_data", d0, tv[i].data);
      chk("tv out_valid", v0, tv[i].valid);
      chk("tv wrap", w0, tv[i].wrap);
      chk("tv sel_err", e0, tv[i].err);
    end
    din = 16'hDCBA; mode = 0; sel = 0;
    step();
    mode = 1;
    for (int k = 0; k < 13; k++) begin
      step();
      chk("scan ch_idx", i0, exp34[k]);
      chk("scan wrap", w0, int'(k == 12));
    end
    mode = 0; sel = 1;
    step();
    mode = 1;
    step();
    step();
    hold = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold ch_idx", i0, 1);
    end
    hold = 0;
    step();
    chk("release ch_idx", i0, 1);
    step();
    chk("resume ch_idx", i0, 2);
    mode = 0; sel = 1;
    step();
    chk("u1 manual ch_idx", i1, 1);
    sel = 3;
    step();
    chk("u1 bad sel ch_idx", i1, 1);
    chk("u1 bad sel sel_err", e1, 1);
    mode = 1;
    for (int k = 0; k < 4; k++) step();
    chk("u1 scan ch_idx", i1, 2);
    rst = 1;
    step();
    chk("u1 reset ch_idx", i1, 0);
    chk("u1 reset out_valid", v1, 0);
    rst = 0;
    for (int k = 0; k < 400; k++) begin
      rst = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      hold = $urandom_range(0, 3) == 0;
      sel = 2'($urandom);
      din = 16'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
